// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states and datapath select codes.
package multicycle_control_unit_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    // Opcodes that need an EX cycle; anything else leaving ID is a NOP or ECALL.
    function automatic logic is_ex_opcode(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/mc_latency_counter.sv
// Memory-latency counter: counts cycles spent in an access and flags the final one.
module mc_latency_counter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last_cycle
);

    logic [CNT_W-1:0] r_cnt;

    assign o_last_cycle = (r_cnt == CNT_W'(MEM_LAT - 1));

    // Saturates on the last cycle; the owning FSM clears it when it leaves the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_last_cycle) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB and drives datapath selects and enables.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       x17_is_10,
    output logic       pc_write,
    output logic       old_pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       pc_to_reg,
    output logic       reg_write,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       is_halted
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_e r_state;
    state_e w_next;
    logic   w_last;
    logic   w_cnt_clear;
    logic   w_cnt_en;

    assign w_cnt_en    = (r_state == S_IF) || (r_state == S_MEM);
    assign w_cnt_clear = (w_next != r_state);

    mc_latency_counter #(
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) u_lat_cnt (
        .clk          (clk),
        .rst_n        (reset),
        .i_clear      (w_cnt_clear),
        .i_enable     (w_cnt_en),
        .o_last_cycle (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF: begin
                if (w_last) w_next = S_ID;
            end
            S_ID: begin
                if (opcode == OP_SYSTEM) begin
                    w_next = x17_is_10 ? S_HALT : S_IF;
                end else if (is_ex_opcode(opcode)) begin
                    w_next = S_EX;
                end else begin
                    w_next = S_IF;
                end
            end
            S_EX: begin
                case (opcode)
                    OP_RTYPE, OP_IMM:  w_next = S_WB;
                    OP_LOAD, OP_STORE: w_next = S_MEM;
                    default:           w_next = S_IF;
                endcase
            end
            S_MEM: begin
                if (w_last) w_next = (opcode == OP_LOAD) ? S_WB : S_IF;
            end
            S_WB:    w_next = S_IF;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    // Reset gates every output so an aborted access never leaves a strobe high.
    always_comb begin
        pc_write     = 1'b0;
        old_pc_write = 1'b0;
        i_or_d       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        mem_to_reg   = 1'b0;
        pc_to_reg    = 1'b0;
        reg_write    = 1'b0;
        pc_source    = PC_SRC_ALU;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        is_halted    = 1'b0;
        if (reset) begin
            case (r_state)
                S_IF: begin
                    mem_read = 1'b1;
                    if (w_last) begin
                        ir_write     = 1'b1;
                        old_pc_write = 1'b1;
                        pc_write     = 1'b1;
                        alu_src_b    = SRC_B_FOUR;
                    end
                end
                S_ID: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                S_EX: begin
                    case (opcode)
                        OP_RTYPE: begin
                            alu_src_a = SRC_A_RS1;
                            alu_op    = ALU_FUNCT;
                        end
                        OP_IMM: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_FUNCT;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                        end
                        OP_BRANCH: begin
                            alu_src_a = SRC_A_RS1;
                            alu_op    = ALU_BRANCH;
                            pc_write  = bcond;
                            pc_source = PC_SRC_ALUOUT;
                        end
                        OP_JAL: begin
                            reg_write = 1'b1;
                            pc_to_reg = 1'b1;
                            pc_write  = 1'b1;
                            pc_source = PC_SRC_ALUOUT;
                        end
                        OP_JALR: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            reg_write = 1'b1;
                            pc_to_reg = 1'b1;
                            pc_write  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = (opcode == OP_LOAD);
                    mem_write = (opcode == OP_STORE);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (opcode == OP_LOAD);
                end
                S_HALT:  is_halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: three control units (MEM_LAT 1, 3, 4) share stimulus; packed outputs are checked per cycle.
module tb_multicycle_control_unit;

    // Packed output word: {pc_write, old_pc_write, i_or_d, mem_read, mem_write, ir_write,
    //                      mem_to_reg, pc_to_reg, reg_write, pc_source, src_a[2], src_b[2], alu_op[2], is_halted}
    localparam logic [16:0] B_HALT  = 17'h00001;
    localparam logic [16:0] AOP_BR  = 17'h00002;
    localparam logic [16:0] AOP_FN  = 17'h00004;
    localparam logic [16:0] SB_4    = 17'h00008;
    localparam logic [16:0] SB_IMM  = 17'h00010;
    localparam logic [16:0] SA_OLD  = 17'h00020;
    localparam logic [16:0] SA_A    = 17'h00040;
    localparam logic [16:0] B_PCSRC = 17'h00080;
    localparam logic [16:0] B_RW    = 17'h00100;
    localparam logic [16:0] B_P2R   = 17'h00200;
    localparam logic [16:0] B_M2R   = 17'h00400;
    localparam logic [16:0] B_IRW   = 17'h00800;
    localparam logic [16:0] B_MWR   = 17'h01000;
    localparam logic [16:0] B_MRD   = 17'h02000;
    localparam logic [16:0] B_IOD   = 17'h04000;
    localparam logic [16:0] B_OPCW  = 17'h08000;
    localparam logic [16:0] B_PCW   = 17'h10000;

    localparam logic [16:0] E_ZERO    = 17'h00000;
    localparam logic [16:0] E_IF_W    = B_MRD;
    localparam logic [16:0] E_IF_L    = B_PCW | B_OPCW | B_MRD | B_IRW | SB_4;
    localparam logic [16:0] E_ID      = SA_OLD | SB_IMM;
    localparam logic [16:0] E_EX_R    = SA_A | AOP_FN;
    localparam logic [16:0] E_EX_I    = SA_A | SB_IMM | AOP_FN;
    localparam logic [16:0] E_EX_LS   = SA_A | SB_IMM;
    localparam logic [16:0] E_EX_BR0  = SA_A | AOP_BR | B_PCSRC;
    localparam logic [16:0] E_EX_BR1  = SA_A | AOP_BR | B_PCSRC | B_PCW;
    localparam logic [16:0] E_EX_JAL  = B_RW | B_P2R | B_PCW | B_PCSRC;
    localparam logic [16:0] E_EX_JALR = SA_A | SB_IMM | B_RW | B_P2R | B_PCW;
    localparam logic [16:0] E_MEM_LD  = B_IOD | B_MRD;
    localparam logic [16:0] E_MEM_ST  = B_IOD | B_MWR;
    localparam logic [16:0] E_WB      = B_RW;
    localparam logic [16:0] E_WB_LD   = B_RW | B_M2R;
    localparam logic [16:0] E_HALT    = B_HALT;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       x17_is_10;
    wire [16:0] v1;
    wire [16:0] v3;
    wire [16:0] v4;

    int n_checks = 0;
    int n_errors = 0;
    logic [16:0] q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17_is_10(x17_is_10),
        .pc_write(v1[16]), .old_pc_write(v1[15]), .i_or_d(v1[14]), .mem_read(v1[13]),
        .mem_write(v1[12]), .ir_write(v1[11]), .mem_to_reg(v1[10]), .pc_to_reg(v1[9]),
        .reg_write(v1[8]), .pc_source(v1[7]), .alu_src_a(v1[6:5]), .alu_src_b(v1[4:3]),
        .alu_op(v1[2:1]), .is_halted(v1[0])
    );

    multicycle_control_unit #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17_is_10(x17_is_10),
        .pc_write(v3[16]), .old_pc_write(v3[15]), .i_or_d(v3[14]), .mem_read(v3[13]),
        .mem_write(v3[12]), .ir_write(v3[11]), .mem_to_reg(v3[10]), .pc_to_reg(v3[9]),
        .reg_write(v3[8]), .pc_source(v3[7]), .alu_src_a(v3[6:5]), .alu_src_b(v3[4:3]),
        .alu_op(v3[2:1]), .is_halted(v3[0])
    );

    multicycle_control_unit #(.MEM_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17_is_10(x17_is_10),
        .pc_write(v4[16]), .old_pc_write(v4[15]), .i_or_d(v4[14]), .mem_read(v4[13]),
        .mem_write(v4[12]), .ir_write(v4[11]), .mem_to_reg(v4[10]), .pc_to_reg(v4[9]),
        .reg_write(v4[8]), .pc_source(v4[7]), .alu_src_a(v4[6:5]), .alu_src_b(v4[4:3]),
        .alu_op(v4[2:1]), .is_halted(v4[0])
    );

    function automatic logic [16:0] obs(input int sel);
        case (sel)
            1:       return v1;
            3:       return v3;
            default: return v4;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves all units in the first IF cycle with the latency counter at zero.
    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    // One check per cycle against the expected output words, advancing a clock after each.
    task automatic run_seq(input string tag, input int sel, input logic [16:0] exp_q[$]);
        foreach (exp_q[i]) begin
            check_eq($sformatf("%s[%0d]", tag, i), obs(sel), exp_q[i]);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = OPC_R;
        bcond     = 1'b0;
        x17_is_10 = 1'b0;
        tick();
        tick();
        check_eq("reset_lat1", v1, E_ZERO);
        check_eq("reset_lat3", v3, E_ZERO);
        check_eq("reset_lat4", v4, E_ZERO);

        opcode = OPC_R;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_R, E_WB, E_IF_L};
        run_seq("rtype", 1, q);

        opcode = OPC_IMM;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_I, E_WB, E_IF_L};
        run_seq("arith_imm", 1, q);

        opcode = OPC_LOAD;
        do_reset();
        q = {E_IF_W, E_IF_W, E_IF_L, E_ID, E_EX_LS, E_MEM_LD, E_MEM_LD, E_MEM_LD, E_WB_LD, E_IF_W};
        run_seq("load_lat3", 3, q);

        opcode = OPC_BRANCH;
        bcond  = 1'b0;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_BR0, E_IF_L};
        run_seq("branch_nt", 1, q);
        bcond = 1'b1;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_BR1, E_IF_L};
        run_seq("branch_t", 1, q);
        bcond = 1'b0;

        opcode = OPC_JALR;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_JALR, E_IF_L};
        run_seq("jalr", 1, q);

        opcode = OPC_JAL;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_JAL, E_IF_L};
        run_seq("jal", 1, q);

        opcode = OPC_STORE;
        do_reset();
        q = {E_IF_L, E_ID, E_EX_LS, E_MEM_ST, E_IF_L};
        run_seq("store_lat1", 1, q);

        opcode = OPC_LUI;
        do_reset();
        q = {E_IF_L, E_ID, E_IF_L};
        run_seq("unknown_nop", 1, q);

        opcode    = OPC_ECALL;
        x17_is_10 = 1'b1;
        do_reset();
        q = {E_IF_L, E_ID, E_HALT};
        run_seq("ecall_halt", 1, q);
        for (int i = 0; i < 20; i++) begin
            opcode    = 7'($urandom);
            x17_is_10 = 1'($urandom);
            check_eq($sformatf("halt_hold[%0d]", i), v1, E_HALT);
            tick();
        end

        opcode    = OPC_ECALL;
        x17_is_10 = 1'b0;
        do_reset();
        q = {E_IF_L, E_ID, E_IF_L, E_ID};
        run_seq("ecall_cont", 1, q);

        opcode = OPC_STORE;
        do_reset();
        q = {E_IF_W, E_IF_W, E_IF_W, E_IF_L, E_ID, E_EX_LS, E_MEM_ST};
        run_seq("store_lat4", 4, q);
        check_eq("store_lat4_mem2", v4, E_MEM_ST);
        reset = 1'b0;
        #1;
        check_eq("abort_zero", v4, E_ZERO);
        tick();
        check_eq("abort_held", v4, E_ZERO);
        reset = 1'b1;
        #1;
        q = {E_IF_W, E_IF_W, E_IF_W, E_IF_L, E_ID, E_EX_LS, E_MEM_ST};
        run_seq("after_abort", 4, q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
